// File: rtl/rom_reader.sv
// rom_reader: sequencing read master for the table ROM.
// Walks LEN consecutive ROM addresses starting at BASE and presents each word
// on a valid/ready stream. It keeps a running sum of the accepted words and
// pulses o_done for one cycle once the last word has been taken.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for i_start; outputs hold the previous sweep's results
// S_FETCH | o_addr is on the ROM bus; capture i_rom_data at the next edge
// S_HOLD  | o_dout presented with o_dout_valid until i_dout_ready
// S_DONE  | one-cycle o_done pulse, then back to S_IDLE
module rom_reader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 4,
   parameter int BASE   = 0,
   parameter int LEN    = 8,
   parameter int SUM_W  = 12
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_abort,
   output logic [ADDR_W-1:0] o_addr,
   input  logic [DATA_W-1:0] i_rom_data,
   output logic [DATA_W-1:0] o_dout,
   output logic              o_dout_valid,
   input  logic              i_dout_ready,
   output logic              o_busy,
   output logic              o_done,
   output logic [SUM_W-1:0]  o_sum
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // The count is one bit wider than the address so a full 2^ADDR_W sweep fits.
   localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W+1)'(LEN - 1);
   localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_count;
   logic [DATA_W-1:0] r_dout;
   logic              r_dout_valid;
   logic [SUM_W-1:0]  r_sum;

   logic w_start_ok;
   logic w_abort_ok;
   logic w_accept;
   logic w_last;
   logic w_advance;

   // start only matters in IDLE; abort only matters outside IDLE, so the
   // two can never collide and start wins when both are high in IDLE.
   assign w_start_ok = (r_state == S_IDLE) && i_start;
   assign w_abort_ok = (r_state != S_IDLE) && i_abort;

   // Abort beats ready: a word that is aborted is never counted or summed.
   assign w_accept  = (r_state == S_HOLD) && i_dout_ready && !i_abort;
   assign w_last    = (r_count == LAST_CNT);
   assign w_advance = w_accept && !w_last;

   // Next-state selection; abort overrides every other transition.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_state_nxt = S_FETCH;
         S_FETCH: w_state_nxt = S_HOLD;
         S_HOLD:  if (i_dout_ready) w_state_nxt = w_last ? S_DONE : S_FETCH;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_abort_ok) w_state_nxt = S_IDLE;
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // ROM address: loaded with BASE at start, wraps naturally at 2^ADDR_W.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)        r_addr <= '0;
      else if (w_start_ok) r_addr <= BASE_ADDR;
      else if (w_advance)  r_addr <= r_addr + ADDR_W'(1);
   end

   // Index of the word currently being fetched or presented.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)        r_count <= '0;
      else if (w_start_ok) r_count <= '0;
      else if (w_advance)  r_count <= r_count + (ADDR_W+1)'(1);
   end

   // Output word: captured from the combinational ROM during FETCH.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)                                r_dout <= '0;
      else if ((r_state == S_FETCH) && !i_abort)   r_dout <= i_rom_data;
   end

   // Valid flag: raised when a word is captured, dropped on accept or abort.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)                     r_dout_valid <= 1'b0;
      else if (w_abort_ok)              r_dout_valid <= 1'b0;
      else if (r_state == S_FETCH)      r_dout_valid <= 1'b1;
      else if (w_accept)                r_dout_valid <= 1'b0;
   end

   // Running sum, modulo 2^SUM_W; cleared only by an accepted start.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)        r_sum <= '0;
      else if (w_start_ok) r_sum <= '0;
      else if (w_accept)   r_sum <= r_sum + SUM_W'(r_dout);
   end

   assign o_addr       = r_addr;
   assign o_dout       = r_dout;
   assign o_dout_valid = r_dout_valid;
   assign o_sum        = r_sum;
   assign o_busy       = (r_state != S_IDLE);
   assign o_done       = (r_state == S_DONE);

endmodule

// File: tb/tb_rom_reader.sv
// Bench for rom_reader: one default instance (BASE 0, LEN 8) and one wrapping
// instance (BASE 254, LEN 4), both fed by a ROM holding 2*addr for 0..7.
module tb_rom_reader;

   localparam int AW = 8;
   localparam int DW = 4;
   localparam int SW = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, start, abort, ready;
   logic          w_start, w_abort, w_ready;
   logic [AW-1:0] addr, w_addr;
   logic [DW-1:0] rdata, w_rdata, dout, w_dout;
   logic          valid, w_valid, busy, w_busy, done, w_done;
   logic [SW-1:0] sum, w_sum;

   function automatic logic [DW-1:0] rom_f(input int a);
      return (a < 8) ? DW'(2 * a) : '0;
   endfunction

   assign rdata   = rom_f(int'(addr));
   assign w_rdata = rom_f(int'(w_addr));

   rom_reader #(.ADDR_W(AW), .DATA_W(DW), .BASE(0), .LEN(8), .SUM_W(SW)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
      .o_addr(addr), .i_rom_data(rdata), .o_dout(dout), .o_dout_valid(valid),
      .i_dout_ready(ready), .o_busy(busy), .o_done(done), .o_sum(sum));

   rom_reader #(.ADDR_W(AW), .DATA_W(DW), .BASE(254), .LEN(4), .SUM_W(SW)) u_wrap (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(w_start), .i_abort(w_abort),
      .o_addr(w_addr), .i_rom_data(w_rdata), .o_dout(w_dout), .o_dout_valid(w_valid),
      .i_dout_ready(w_ready), .o_busy(w_busy), .o_done(w_done), .o_sum(w_sum));

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: a sweep is active or not; within it the reader
   // alternates a fetch cycle (no valid) with a presentation phase that lasts
   // until accepted, and emits one done cycle after the LEN-th acceptance.
   int base_of [2] = '{0, 254};
   int len_of  [2] = '{8, 4};
   int m_k     [2] = '{0, 0};
   int m_sum   [2] = '{0, 0};
   bit m_active[2] = '{1'b0, 1'b0};
   bit m_fetch [2] = '{1'b0, 1'b0};
   bit m_done  [2] = '{1'b0, 1'b0};

   task automatic model_step(input int i, input bit rst, input bit st, input bit ab,
                             input bit rdy, input bit v, input bit dn, input bit b,
                             input int a, input int d, input int s);
      bit exp_v;
      int exp_a;
      exp_v = m_active[i] && !m_fetch[i] && !m_done[i];
      exp_a = (base_of[i] + m_k[i]) % 256;
      if (chk_en) begin
         chk($sformatf("valid[%0d]", i), int'(v), int'(exp_v));
         chk($sformatf("done[%0d]", i), int'(dn), int'(m_done[i]));
         chk($sformatf("busy[%0d]", i), int'(b), int'(m_active[i]));
         chk($sformatf("sum[%0d]", i), s, m_sum[i]);
         if (v && dn) chk($sformatf("done_with_valid[%0d]", i), 1, 0);
         if (exp_v) begin
            chk($sformatf("addr[%0d]", i), a, exp_a);
            chk($sformatf("dout[%0d]", i), d, int'(rom_f(exp_a)));
         end
      end
      if (!rst) begin
         m_active[i] = 1'b0; m_fetch[i] = 1'b0; m_done[i] = 1'b0;
         m_sum[i] = 0; m_k[i] = 0;
      end else if (m_active[i] && ab) begin
         m_active[i] = 1'b0; m_fetch[i] = 1'b0; m_done[i] = 1'b0;
      end else if (!m_active[i] && st) begin
         m_active[i] = 1'b1; m_fetch[i] = 1'b1; m_k[i] = 0; m_sum[i] = 0;
      end else if (m_done[i]) begin
         m_done[i] = 1'b0; m_active[i] = 1'b0;
      end else if (m_fetch[i]) begin
         m_fetch[i] = 1'b0;
      end else if (exp_v && rdy) begin
         m_sum[i] = (m_sum[i] + int'(rom_f(exp_a))) % 4096;
         if (m_k[i] == len_of[i] - 1) m_done[i] = 1'b1;
         else begin
            m_k[i]++;
            m_fetch[i] = 1'b1;
         end
      end
   endtask

   // Compare process: outputs and inputs are both stable at the falling edge.
   always @(negedge clk) begin
      model_step(0, rst_n, start, abort, ready, valid, done, busy,
                 int'(addr), int'(dout), int'(sum));
      model_step(1, rst_n, w_start, w_abort, w_ready, w_valid, w_done, w_busy,
                 int'(w_addr), int'(w_dout), int'(w_sum));
   end

   // Per-cycle observations of the last sweep, indexed by relative cycle.
   int ov[32], od[32], oa[32], ob[32], on[32], os[32];
   int wv[32], wd[32], wa[32], wn[32], ws[32];

   // Runs 24 cycles; cycle r is the state after the r-th edge counted from
   // the edge that samples start. Negative arguments disable a feature.
   task automatic sweep(input int s1, input int s2, input int stall_c, input int stall_n,
                        input int abort_c, input int rst_c, input bit wrap_go);
      for (int r = 0; r < 24; r++) begin
         if (r > 0) begin
            @(posedge clk); #2;
            ov[r] = int'(valid); od[r] = int'(dout); oa[r] = int'(addr);
            ob[r] = int'(busy);  on[r] = int'(done); os[r] = int'(sum);
            wv[r] = int'(w_valid); wd[r] = int'(w_dout); wa[r] = int'(w_addr);
            wn[r] = int'(w_done);  ws[r] = int'(w_sum);
         end
         start   = (r == 0) || (r == s1) || (r == s2);
         w_start = wrap_go && (r == 0);
         ready   = !((r >= stall_c) && (r < stall_c + stall_n));
         abort   = (r == abort_c);
         rst_n   = !(r + 1 == rst_c);
      end
      start = 1'b0; w_start = 1'b0; ready = 1'b1; abort = 1'b0; rst_n = 1'b1;
   endtask

   function automatic int count_done();
      int n = 0;
      for (int r = 1; r < 24; r++) n += on[r];
      return n;
   endfunction

   task automatic check_default_words(input string tag);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("%s_v%0d", tag, k), ov[2 + 2 * k], 1);
         chk($sformatf("%s_d%0d", tag, k), od[2 + 2 * k], 2 * k);
         chk($sformatf("%s_gap%0d", tag, k), ov[3 + 2 * k], 0);
      end
      chk({tag, "_done17"}, on[17], 1);
      chk({tag, "_ndone"}, count_done(), 1);
      chk({tag, "_sum"}, os[18], 56);
   endtask

   initial begin
      int n4;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b1;
      w_start = 1'b0; w_abort = 1'b0; w_ready = 1'b1;
      @(posedge clk); #2;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_addr", int'(addr), 0);
      chk("rst_dout", int'(dout), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_sum", int'(sum), 0);
      rst_n = 1'b1;
      @(posedge clk); #2;

      // Default sweep plus the wrapping instance.
      sweep(-1, -1, -1, 0, -1, -1, 1'b1);
      check_default_words("dflt");
      chk("dflt_busy1", ob[1], 1);
      chk("dflt_busy17", ob[17], 1);
      chk("dflt_busy18", ob[18], 0);
      chk("wrap_a0", wa[2], 254); chk("wrap_a1", wa[4], 255);
      chk("wrap_a2", wa[6], 0);   chk("wrap_a3", wa[8], 1);
      chk("wrap_d0", wd[2], 0);   chk("wrap_d3", wd[8], 2);
      chk("wrap_done9", wn[9], 1);
      chk("wrap_sum", ws[10], 2);

      // Backpressure on the word at addr 2.
      sweep(-1, -1, 6, 3, -1, -1, 1'b0);
      n4 = 0;
      for (int r = 1; r < 24; r++) if (ov[r] == 1 && od[r] == 4) n4++;
      chk("bp_hold_cycles", n4, 4);
      chk("bp_done17", on[17], 0);
      chk("bp_done20", on[20], 1);
      chk("bp_sum", os[21], 56);

      // Start pulses while busy are ignored.
      sweep(3, 5, -1, 0, -1, -1, 1'b0);
      check_default_words("sbusy");

      // Abort during HOLD of the third word with ready high.
      sweep(-1, -1, -1, 0, 6, -1, 1'b0);
      chk("ab_v6", ov[6], 1);
      chk("ab_v7", ov[7], 0);
      chk("ab_busy7", ob[7], 0);
      chk("ab_sum7", os[7], 2);
      chk("ab_ndone", count_done(), 0);
      chk("ab_sum_end", os[23], 2);
      sweep(-1, -1, -1, 0, -1, -1, 1'b0);
      chk("ab_restart_sum1", os[1], 0);
      check_default_words("ab_restart");

      // Synchronous reset at edge 7 of a sweep.
      sweep(-1, -1, -1, 0, -1, 7, 1'b0);
      chk("rm_sum6", os[6], 2);
      chk("rm_addr7", oa[7], 0);
      chk("rm_dout7", od[7], 0);
      chk("rm_valid7", ov[7], 0);
      chk("rm_busy7", ob[7], 0);
      chk("rm_done7", on[7], 0);
      chk("rm_sum7", os[7], 0);
      chk("rm_ndone", count_done(), 0);
      sweep(-1, -1, -1, 0, -1, -1, 1'b0);
      check_default_words("rm_restart");

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rom_reader.md
# rom_reader

Sequencing read master for the table ROM. On a `start` pulse it walks `LEN` consecutive ROM addresses from `BASE` and presents each returned word on a valid/ready output stream. It also keeps a running sum of the accepted words and pulses `done` when the sweep completes. It sits between the ROM (which it drives and samples) and any downstream consumer of table contents.

## Interface
- `ADDR_W`, 8, ROM address width
- `DATA_W`, 4, ROM data width
- `BASE`, 0, first address of the sweep
- `LEN`, 8, number of words per sweep; legal range 1..2^ADDR_W
- `SUM_W`, 12, width of the running sum
- `clk` in 1: the single clock; all logic on its rising edge
- `rst_n` in 1: synchronous, active-low reset, sampled on `clk` rising edge
- `start` in 1: begin a sweep; honoured only in IDLE
- `abort` in 1: cancel the sweep in progress
- `addr_o` out ADDR_W: address to the ROM, registered
- `rom_data` in DATA_W: ROM read data; combinational from `addr_o`, valid in the same cycle
- `dout` out DATA_W: output word, registered
- `dout_valid` out 1: `dout` holds an unaccepted word
- `dout_ready` in 1: downstream accepts `dout` when high with `dout_valid`
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse after the last word is accepted
- `sum` out SUM_W: modulo-2^SUM_W sum of words accepted in the current or last sweep

## Operation
- States: IDLE, FETCH, HOLD, DONE.
- IDLE:
  - `start`=1 → `addr_o`<=BASE, count<=0, `sum`<=0, go to FETCH.
  - `start`=0 → stay.
- FETCH: `dout`<=`rom_data`, `dout_valid`<=1, go to HOLD.
- HOLD: `dout`/`dout_valid` held stable while `dout_ready`=0. On `dout_ready`=1:
  - `sum`<=`sum`+`dout`, `dout_valid`<=0.
  - If count==LEN-1, go to DONE.
  - Otherwise count<=count+1, `addr_o`<=`addr_o`+1, go to FETCH.
- DONE: `done`=1 for this cycle only, then go to IDLE. `sum` holds its final value until the next accepted `start`.
- `addr_o` increments modulo 2^ADDR_W: 255+1 → 0 at the default width.
- The count register is ADDR_W+1 bits so that LEN=256 is representable.
- `start` in any state other than IDLE is ignored.
- `abort`=1 in FETCH, HOLD or DONE:
  - Next state is IDLE, `dout_valid`<=0, no `done` pulse.
  - `sum` and `addr_o` keep their values at the abort.
  - `abort` has priority over `dout_ready` in the same cycle; the word is not counted.
  - `abort` in IDLE has no effect.
- `abort` and `start` both high in IDLE → `start` wins.
- Reset (`rst_n`=0 at an edge, in any state, mid-sweep included): state IDLE, `addr_o`=0, `dout`=0, `dout_valid`=0, `busy`=0, `done`=0, `sum`=0, count=0.

## Timing
- Cycle n = state after rising edge n. `start` sampled at edge 0.
- FETCH in cycle 1 with `addr_o`=BASE.
- First word valid in cycle 2.
- With `dout_ready` held high, word k is valid in cycle 2+2k, giving one word per 2 cycles.
- The last word is accepted in cycle 2·LEN; `done` is high in cycle 2·LEN+1; IDLE in cycle 2·LEN+2.
- Each cycle of `dout_ready`=0 in HOLD delays all later events by one cycle.
- `busy` rises in cycle 1 and falls in the cycle after `done`.
- A new `start` may be accepted in the first IDLE cycle after DONE.
- `done` and `dout_valid` are never high in the same cycle.

## Test plan
- Default sweep (BASE=0, LEN=8, ROM table 2·addr for 0..7), `dout_ready`=1, `start` at edge 0 → `dout` 0,2,4,…,14 valid in cycles 2,4,…,16; `done` in cycle 17; `sum`=56; `busy` cycles 1–17.
- Backpressure: `dout_ready`=0 for 3 cycles while the word 4 (addr 2) is presented → `dout`=4, `dout_valid`=1 stable for 4 cycles; `done` moves to cycle 20; `sum`=56.
- Wrap: BASE=254, LEN=4 → `addr_o` 254,255,0,1; `dout` 0,0,0,2 (ROM default 0 beyond 7); `sum`=2; `done` in cycle 9.
- Start while busy: pulse `start` in cycles 3 and 5 of a default sweep → no restart; output sequence and `done` cycle identical to the first test.
- Abort during HOLD of the 3rd word, with `dout_ready`=1 in the same cycle → IDLE next cycle, `dout_valid`=0, no `done`, `sum`=2. A following `start` clears `sum` and completes a normal sweep with `sum`=56.
- Reset mid-sweep: `rst_n`=0 at edge 7 → cycle 7 shows `addr_o`=0, `dout`=0, `dout_valid`=0, `busy`=0, `done`=0, `sum`=0. After release, `start` gives a normal sweep.
